// File: rtl/icache_axi_refill.sv
// icache_axi_refill: AXI4 read master that refills one icache line (or one uncached word) per request
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_i, cached_i, paddr_i    fetch request (level), full-line vs single-word, physical address
//   busy_o, rend_o              busy while not idle; one-cycle pulse when line_o/err_o are valid
//   line_o, err_o               refill data (word i at [32i+31:32i]); any beat returned non-OKAY
//   ar*_o, arready_i            AXI read address channel
//   r*_i, rready_o              AXI read data channel
module icache_axi_refill #(
  parameter logic [3:0] AXI_ID     = 4'd0,
  parameter int         LINE_WORDS = 8,
  parameter int         LINE_W     = 32 * LINE_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              cached_i,
  input  logic [31:0]       paddr_i,
  output logic              busy_o,
  output logic              rend_o,
  output logic [LINE_W-1:0] line_o,
  output logic              err_o,
  output logic [3:0]        arid_o,
  output logic [31:0]       araddr_o,
  output logic [7:0]        arlen_o,
  output logic [2:0]        arsize_o,
  output logic [1:0]        arburst_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [31:0]       rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rlast_i,
  input  logic              rvalid_i,
  output logic              rready_o
);
  localparam int          CW        = $clog2(LINE_WORDS);
  localparam logic [31:0] LINE_MASK = 32'(LINE_W / 8 - 1);
  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;
  state_t state, state_next;
  logic [CW-1:0] cnt;
  logic accept, beat;
  assign arid_o    = AXI_ID;
  assign arsize_o  = 3'b010;
  assign arburst_o = 2'b01;
  assign accept    = state == IDLE && req_i;
  assign beat      = rready_o && rvalid_i;
  always_ff @(posedge clk) state <= rst_n ? state_next : IDLE;
  always_comb begin
    state_next = state;
    busy_o     = state != IDLE;
    arvalid_o  = 1'b0;
    rready_o   = 1'b0;
    rend_o     = 1'b0;
    case (state)
      IDLE: state_next = req_i ? AR : IDLE;
      AR: begin
        arvalid_o  = 1'b1;
        state_next = arready_i ? R : AR;
      end
      R: begin
        rready_o   = 1'b1;
        state_next = rvalid_i && rlast_i ? DONE : R;
      end
      default: begin
        rend_o     = 1'b1;
        state_next = IDLE;
      end
    endcase
  end
  // Beat counter wraps, so an over-long burst overwrites from word 0; a short burst leaves zeros.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      araddr_o <= '0;
      arlen_o  <= '0;
      line_o   <= '0;
      err_o    <= 1'b0;
      cnt      <= '0;
    end else if (accept) begin
      araddr_o <= cached_i ? paddr_i & ~LINE_MASK : paddr_i & ~32'd3;
      arlen_o  <= cached_i ? 8'(LINE_WORDS - 1) : 8'd0;
      line_o   <= '0;
      err_o    <= 1'b0;
      cnt      <= '0;
    end else if (beat) begin
      line_o[32*cnt +: 32] <= rdata_i;
      cnt                  <= cnt + 1'b1;
      err_o                <= err_o | (rresp_i != 2'b00);
    end
  end
endmodule

// File: tb/tb_icache_axi_refill.sv
// tb_icache_axi_refill: randomized AXI slave plus line-level reference model for icache_axi_refill
module tb_icache_axi_refill;
  logic         clk = 1'b0, rst_n = 1'b0, req = 1'b0, cached = 1'b0;
  logic [31:0]  paddr = '0, rdata = '0;
  logic [1:0]   rresp = '0;
  logic         rlast = 1'b0, rvalid = 1'b0, arready = 1'b0;
  logic         busy, rend, err, arvalid, rready;
  logic [255:0] line;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  int errs = 0, checks = 0;
  logic [31:0]  bd[$];
  logic [1:0]   br[$];
  logic [15:0]  gap_mask = '0;
  logic [31:0]  o_araddr;
  logic [7:0]   o_arlen;
  bit           o_ar_unstable, o_arv_after;
  int           o_rend_cnt, o_rend_it, o_ar_hs;
  logic [255:0] o_line, o_rst_line;
  logic         o_err;
  logic [4:0]   o_rst;

  icache_axi_refill dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .cached_i(cached), .paddr_i(paddr),
    .busy_o(busy), .rend_o(rend), .line_o(line), .err_o(err),
    .arid_o(arid), .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize), .arburst_o(arburst),
    .arvalid_o(arvalid), .arready_i(arready),
    .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast), .rvalid_i(rvalid), .rready_o(rready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_addr(input logic [31:0] pa, input logic c);
    return c ? pa - (pa % 32) : pa - (pa % 4);
  endfunction

  function automatic logic [255:0] model_line();
    logic [255:0] l = '0;
    for (int i = 0; i < bd.size(); i++) l[32*(i%8) +: 32] = bd[i];
    return l;
  endfunction

  function automatic logic model_err();
    logic e = 1'b0;
    foreach (br[i]) e |= (br[i] != 2'b00);
    return e;
  endfunction

  task automatic fill(input int n, input int err_beat);
    bd = {};
    br = {};
    for (int i = 0; i < n; i++) begin
      bd.push_back($urandom);
      br.push_back(i == err_beat ? 2'(1 + $urandom_range(0, 2)) : 2'b00);
    end
  endtask

  // Acts as the AXI slave for one request and records what the DUT did; starts and ends at a negedge.
  task automatic drive(input logic [31:0] pa, input logic c, input int ar_wait, input int gap_pct,
                       input int abort_at, input bit toggle, input bit hold);
    int ar_seen = 0, bi = 0, nb = bd.size();
    bit prev_rr = 0, prev_arv = 0, hold_gap = 0, first_ar = 1, aborting = 0;
    o_ar_unstable = 0; o_arv_after = 0; o_rend_cnt = 0; o_rend_it = 0; o_ar_hs = 0;
    req = 1'b1; paddr = pa; cached = c; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    for (int it = 1; it <= 400; it++) begin
      @(negedge clk);
      if (aborting) begin
        o_rst = {arvalid, rready, busy, rend, err};
        o_rst_line = line;
        rst_n = 1'b1;
        break;
      end
      if (rvalid && prev_rr) begin
        hold_gap = gap_mask[bi];
        bi++;
      end
      if (arready && prev_arv) o_ar_hs++;
      prev_rr = rready;
      prev_arv = arvalid;
      if (abort_at >= 0 && bi == abort_at) begin
        rst_n = 1'b0; req = 1'b0; rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;
        aborting = 1;
        continue;
      end
      if (arvalid && o_rend_cnt == 0) begin
        if (first_ar) begin
          o_araddr = araddr;
          o_arlen = arlen;
        end else if (araddr !== o_araddr || arlen !== o_arlen) o_ar_unstable = 1;
        first_ar = 0;
      end
      if (arvalid) ar_seen++;
      arready = arvalid && ar_seen > ar_wait;
      if (rend) begin
        o_rend_cnt++;
        if (o_rend_cnt == 1) begin
          o_rend_it = it;
          o_line = line;
          o_err = err;
        end
        if (!hold) req = 1'b0;
      end
      if (hold && o_rend_it > 0 && it == o_rend_it + 2) o_arv_after = arvalid;
      rvalid = rready && bi < nb && !hold_gap && ($urandom_range(0, 99) >= gap_pct);
      hold_gap = 0;
      if (rvalid) begin
        rdata = bd[bi];
        rresp = br[bi];
        rlast = (bi == nb - 1);
      end else begin
        rdata = '0; rresp = '0; rlast = 1'b0;
      end
      if (toggle && rready) begin
        req = 1'($urandom_range(0, 1));
        paddr = $urandom;
        cached = 1'($urandom_range(0, 1));
      end
      if (o_rend_cnt > 0 && it >= o_rend_it + 2) break;
    end
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b1; paddr = 32'h1234_5678; cached = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({busy, arvalid, rready, rend, err} !== 5'b0) begin errs++; $display("FAIL reset_ctrl got=%b exp=00000", {busy, arvalid, rready, rend, err}); end
    checks++; if (line !== 256'b0) begin errs++; $display("FAIL reset_line got=%h exp=0", line); end
    checks++; if ({araddr, arlen} !== 40'b0) begin errs++; $display("FAIL reset_ar got=%h/%h exp=0/0", araddr, arlen); end
    checks++; if ({arid, arsize, arburst} !== {4'd0, 3'b010, 2'b01}) begin errs++; $display("FAIL const_ar got=%h/%b/%b exp=0/010/01", arid, arsize, arburst); end
    req = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_no_req got busy=%b exp=0", busy); end
  endtask

  task automatic test_cached_best();
    logic [255:0] exp_line;
    bd = {}; br = {};
    for (int i = 0; i < 8; i++) begin bd.push_back(32'hA0 + i); br.push_back(2'b00); end
    gap_mask = '0;
    exp_line = model_line();
    drive(32'h1FC0_0014, 1'b1, 0, 0, -1, 0, 0);
    checks++; if (o_araddr !== 32'h1FC0_0000) begin errs++; $display("FAIL best_araddr got=%h exp=1fc00000", o_araddr); end
    checks++; if (o_arlen !== 8'd7) begin errs++; $display("FAIL best_arlen got=%0d exp=7", o_arlen); end
    checks++; if (o_rend_cnt !== 1) begin errs++; $display("FAIL best_rend_count got=%0d exp=1", o_rend_cnt); end
    checks++; if (o_rend_it !== 10) begin errs++; $display("FAIL best_latency got=%0d exp=10", o_rend_it); end
    checks++; if (o_line !== exp_line) begin errs++; $display("FAIL best_line got=%h exp=%h", o_line, exp_line); end
    checks++; if (o_err !== 1'b0) begin errs++; $display("FAIL best_err got=%b exp=0", o_err); end
    repeat (3) @(negedge clk);
    checks++; if (line !== exp_line || err !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL hold_after_rend got=%h/%b/%b exp=%h/0/0", line, err, busy, exp_line); end
  endtask

  task automatic test_stalls();
    logic [31:0] pa = $urandom;
    fill(8, -1);
    gap_mask = 16'h0012;
    drive(pa, 1'b1, 3, 0, -1, 0, 0);
    checks++; if (o_araddr !== model_addr(pa, 1'b1) || o_arlen !== 8'd7) begin errs++; $display("FAIL stall_ar got=%h/%0d exp=%h/7", o_araddr, o_arlen, model_addr(pa, 1'b1)); end
    checks++; if (o_ar_unstable !== 1'b0) begin errs++; $display("FAIL stall_ar_stable got=%b exp=0", o_ar_unstable); end
    checks++; if (o_rend_cnt !== 1) begin errs++; $display("FAIL stall_rend_count got=%0d exp=1", o_rend_cnt); end
    checks++; if (o_rend_it !== 15) begin errs++; $display("FAIL stall_latency got=%0d exp=15", o_rend_it); end
    checks++; if (o_line !== model_line()) begin errs++; $display("FAIL stall_line got=%h exp=%h", o_line, model_line()); end
    gap_mask = '0;
  endtask

  task automatic test_uncached();
    bd = {32'hDEAD_BEEF}; br = {2'b00};
    drive(32'hBFC0_0006, 1'b0, 0, 0, -1, 0, 0);
    checks++; if (o_araddr !== 32'hBFC0_0004 || o_arlen !== 8'd0) begin errs++; $display("FAIL unc_ar got=%h/%0d exp=bfc00004/0", o_araddr, o_arlen); end
    checks++; if (o_line !== {224'b0, 32'hDEAD_BEEF}) begin errs++; $display("FAIL unc_line got=%h exp=deadbeef", o_line); end
    checks++; if (o_rend_it !== 3) begin errs++; $display("FAIL unc_latency got=%0d exp=3", o_rend_it); end
  endtask

  task automatic test_error();
    fill(8, 4);
    drive($urandom, 1'b1, 1, 20, -1, 0, 0);
    checks++; if (o_err !== 1'b1) begin errs++; $display("FAIL err_set got=%b exp=1", o_err); end
    checks++; if (o_line !== model_line()) begin errs++; $display("FAIL err_line got=%h exp=%h", o_line, model_line()); end
    fill(8, -1);
    drive($urandom, 1'b1, 0, 0, -1, 0, 0);
    checks++; if (o_err !== 1'b0) begin errs++; $display("FAIL err_clear got=%b exp=0", o_err); end
  endtask

  task automatic test_short_burst();
    fill(3, -1);
    drive($urandom, 1'b1, 0, 10, -1, 0, 0);
    checks++; if (o_line !== model_line() || o_err !== 1'b0) begin errs++; $display("FAIL short_line got=%h/%b exp=%h/0", o_line, o_err, model_line()); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] pa = $urandom;
    fill(8, 1);
    drive($urandom, 1'b1, 0, 0, 3, 0, 0);
    checks++; if (o_rst !== 5'b0) begin errs++; $display("FAIL midrst_ctrl got arv,rr,busy,rend,err=%b exp=00000", o_rst); end
    checks++; if (o_rst_line !== 256'b0) begin errs++; $display("FAIL midrst_line got=%h exp=0", o_rst_line); end
    fill(8, -1);
    drive(pa, 1'b1, 0, 0, -1, 0, 0);
    checks++; if (o_araddr !== model_addr(pa, 1'b1) || o_line !== model_line() || o_err !== 1'b0) begin errs++; $display("FAIL midrst_after got=%h/%h/%b exp=%h/%h/0", o_araddr, o_line, o_err, model_addr(pa, 1'b1), model_line()); end
  endtask

  task automatic test_ignore_req();
    logic [31:0] pa = $urandom;
    fill(8, -1);
    drive(pa, 1'b1, 0, 30, -1, 1, 0);
    checks++; if (o_ar_hs !== 1) begin errs++; $display("FAIL ignore_ar_count got=%0d exp=1", o_ar_hs); end
    checks++; if (o_araddr !== model_addr(pa, 1'b1) || o_line !== model_line()) begin errs++; $display("FAIL ignore_line got=%h/%h exp=%h/%h", o_araddr, o_line, model_addr(pa, 1'b1), model_line()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa = $urandom;
    fill(8, -1);
    drive(pa, 1'b1, 0, 0, -1, 0, 1);
    checks++; if (o_line !== model_line()) begin errs++; $display("FAIL b2b_first got=%h exp=%h", o_line, model_line()); end
    checks++; if (o_arv_after !== 1'b1) begin errs++; $display("FAIL b2b_second_ar got=%b exp=1", o_arv_after); end
    fill(8, -1);
    drive(pa, 1'b1, 0, 0, -1, 0, 0);
    checks++; if (o_araddr !== model_addr(pa, 1'b1) || o_line !== model_line()) begin errs++; $display("FAIL b2b_second got=%h/%h exp=%h/%h", o_araddr, o_line, model_addr(pa, 1'b1), model_line()); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 15; k++) begin
      logic [31:0] pa = $urandom;
      logic c = 1'($urandom_range(0, 1));
      int n = c ? ($urandom_range(0, 3) == 0 ? int'($urandom_range(1, 8)) : 8) : 1;
      fill(n, $urandom_range(0, 2) == 0 ? int'($urandom_range(0, n - 1)) : -1);
      gap_mask = 16'($urandom);
      drive(pa, c, $urandom_range(0, 3), $urandom_range(0, 30), -1, 0, 0);
      checks++; if (o_araddr !== model_addr(pa, c)) begin errs++; $display("FAIL rnd%0d_araddr got=%h exp=%h", k, o_araddr, model_addr(pa, c)); end
      checks++; if (o_arlen !== (c ? 8'd7 : 8'd0)) begin errs++; $display("FAIL rnd%0d_arlen got=%0d exp=%0d", k, o_arlen, c ? 7 : 0); end
      checks++; if (o_rend_cnt !== 1) begin errs++; $display("FAIL rnd%0d_rend_count got=%0d exp=1", k, o_rend_cnt); end
      checks++; if (o_line !== model_line()) begin errs++; $display("FAIL rnd%0d_line got=%h exp=%h", k, o_line, model_line()); end
      checks++; if (o_err !== model_err()) begin errs++; $display("FAIL rnd%0d_err got=%b exp=%b", k, o_err, model_err()); end
    end
    gap_mask = '0;
  endtask

  initial begin
    test_reset();
    test_cached_best();
    test_stalls();
    test_uncached();
    test_error();
    test_short_burst();
    test_reset_mid();
    test_ignore_req();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
